bus_arbiter_param: RTL and testbench

- Parametrised successor to the serial-bus controller: arbitrates NUM_MASTERS request lines and decodes the slave ID that the granted master shifts onto the serial bus.
- Checks the addressed slave's busy line, then selects that slave or aborts with a NACK.
- Adds selectable round-robin/fixed priority, grant timeout, and error pulses, none of which the current controller has.
- Sits at bus top level, between master request/grant pairs and slave busy/select pairs.

---
 rtl/bus_arb_pkg.sv | 17 +
 rtl/bus_arbiter_param_picker.sv | 34 +++
 rtl/bus_arbiter_param.sv | 172 +++++++++++++++++
 tb/tb_bus_arbiter_param.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared FSM encoding and default widths for the bus arbiter
package bus_arb_pkg;

    localparam int DEF_SID_W     = 3;
    localparam int DEF_MID_W     = 4;
    localparam int DEF_TIMEOUT_W = 6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        ADDR    = 3'd2,
        CHECK   = 3'd3,
        CONNECT = 3'd4,
        RELEASE = 3'd5
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_param_picker.sv
// rtl/bus_arbiter_param_picker.sv - combinational round-robin / fixed-priority winner search
module rr_priority_picker #(
    parameter int N     = 12,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             rr_mode,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    logic [2*N-1:0]   dbl;
    logic [2*N-1:0]   masked;
    logic [IDX_W-1:0] start;

    // The upper copy of the request vector supplies the wrapped-around candidates.
    always_comb begin
        start  = rr_mode ? ptr : '0;
        dbl    = {req, req};
        masked = '0;
        for (int i = 0; i < 2 * N; i++) begin
            masked[i] = dbl[i] && (i >= int'(start));
        end
        winner = '0;
        for (int i = 2 * N - 1; i >= 0; i--) begin
            if (masked[i]) begin
                winner = (i >= N) ? IDX_W'(i - N) : IDX_W'(i);
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/bus_arbiter_param.sv
// rtl/bus_arbiter_param.sv - serial-bus master arbiter with slave ID decode, busy check and timeout
module bus_arbiter_param
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 12,
    parameter int NUM_SLAVES  = 6,
    parameter int SID_W       = DEF_SID_W,
    parameter int MID_W       = DEF_MID_W,
    parameter int TIMEOUT_W   = DEF_TIMEOUT_W,
    parameter int RR_MODE     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] m_reqs,
    output logic [NUM_MASTERS-1:0] m_grants,
    input  logic                   bus_serial,
    input  logic                   bus_util,
    input  logic [NUM_SLAVES-1:0]  slaves_busy,
    output logic [NUM_SLAVES-1:0]  slaves_sel,
    output logic [MID_W-1:0]       mid_current,
    output logic                   mid_valid,
    output logic [2:0]             state,
    output logic                   timeout_err,
    output logic                   slave_nack
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);
    localparam logic [TIMEOUT_W-1:0] ADDR_LAST = TIMEOUT_W'((SID_W > 1) ? SID_W - 2 : 0);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grants_q, grants_d;
    logic [NUM_SLAVES-1:0]  sel_q, sel_d;
    logic [IDX_W-1:0]       mid_q, mid_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic                   valid_q, valid_d;
    logic                   to_q, to_d;
    logic                   nack_q, nack_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic [SID_W-1:0]       sid_q, sid_d;

    logic [IDX_W-1:0]       win;
    logic                   any_req;
    logic [SID_W-1:0]       sid_next;
    logic [NUM_SLAVES-1:0]  sid_hit;
    logic                   busy_hit;

    rr_priority_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (m_reqs),
        .ptr     (ptr_q),
        .rr_mode (RR_MODE != 0),
        .winner  (win),
        .any_req (any_req)
    );

    assign sid_next = SID_W'({sid_q, bus_serial});

    // An empty sid_hit means the captured ID addresses no existing slave.
    always_comb begin
        sid_hit  = '0;
        busy_hit = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sid_q == SID_W'(i)) begin
                sid_hit[i] = 1'b1;
                busy_hit   = slaves_busy[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grants_d = grants_q;
        sel_d    = sel_q;
        mid_d    = mid_q;
        ptr_d    = ptr_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        sid_d    = sid_q;
        to_d     = 1'b0;
        nack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grants_d = NUM_MASTERS'(1) << win;
                    mid_d    = win;
                    valid_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (!bus_util) begin
                    sid_d   = sid_next;
                    cnt_d   = '0;
                    state_d = (SID_W == 1) ? CHECK : ADDR;
                end else if (cnt_q == TO_LAST) begin
                    to_d    = 1'b1;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ADDR: begin
                sid_d = sid_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_LAST) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (!(|sid_hit) || busy_hit) begin
                    nack_d  = 1'b1;
                    state_d = RELEASE;
                end else begin
                    sel_d   = sid_hit;
                    state_d = CONNECT;
                end
            end
            CONNECT: begin
                if (!m_reqs[mid_q] && bus_util) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                grants_d = '0;
                sel_d    = '0;
                valid_d  = 1'b0;
                ptr_d    = (mid_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : mid_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grants_q <= '0;
            sel_q    <= '0;
            mid_q    <= '0;
            ptr_q    <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            sid_q    <= '0;
            to_q     <= 1'b0;
            nack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grants_q <= grants_d;
            sel_q    <= sel_d;
            mid_q    <= mid_d;
            ptr_q    <= ptr_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            sid_q    <= sid_d;
            to_q     <= to_d;
            nack_q   <= nack_d;
        end
    end

    assign m_grants    = grants_q;
    assign slaves_sel  = sel_q;
    assign mid_current = MID_W'(mid_q);
    assign mid_valid   = valid_q;
    assign state       = state_q;
    assign timeout_err = to_q;
    assign slave_nack  = nack_q;

endmodule

// File: tb/tb_bus_arbiter_param.sv
// tb/tb_bus_arbiter_param.sv - directed checks of arbitration, slave decode, timeout and reset
module tb_bus_arbiter_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] m_reqs, m_reqs_fp;
    logic        bus_serial, bus_util;
    logic [5:0]  slaves_busy;

    logic [11:0] g_rr, g_fp;
    logic [5:0]  sel_rr, sel_fp;
    logic [3:0]  mid_rr, mid_fp;
    logic        val_rr, val_fp, to_rr, to_fp, nack_rr, nack_fp;
    logic [2:0]  st_rr, st_fp;

    logic        use_fp;
    logic [11:0] o_grants;
    logic [5:0]  o_sel;
    logic [3:0]  o_mid;
    logic        o_valid, o_to, o_nack;
    logic [2:0]  o_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_arbiter_param dut_rr (
        .clk(clk), .rst(rst), .m_reqs(m_reqs), .m_grants(g_rr),
        .bus_serial(bus_serial), .bus_util(bus_util),
        .slaves_busy(slaves_busy), .slaves_sel(sel_rr),
        .mid_current(mid_rr), .mid_valid(val_rr), .state(st_rr),
        .timeout_err(to_rr), .slave_nack(nack_rr)
    );

    bus_arbiter_param #(.RR_MODE(0)) dut_fp (
        .clk(clk), .rst(rst), .m_reqs(m_reqs_fp), .m_grants(g_fp),
        .bus_serial(bus_serial), .bus_util(bus_util),
        .slaves_busy(slaves_busy), .slaves_sel(sel_fp),
        .mid_current(mid_fp), .mid_valid(val_fp), .state(st_fp),
        .timeout_err(to_fp), .slave_nack(nack_fp)
    );

    always_comb begin
        o_grants = use_fp ? g_fp    : g_rr;
        o_sel    = use_fp ? sel_fp  : sel_rr;
        o_mid    = use_fp ? mid_fp  : mid_rr;
        o_valid  = use_fp ? val_fp  : val_rr;
        o_to     = use_fp ? to_fp   : to_rr;
        o_nack   = use_fp ? nack_fp : nack_rr;
        o_state  = use_fp ? st_fp   : st_rr;
    end

    typedef struct {
        logic        fp;
        logic [11:0] reqs;
        logic [2:0]  sid;
        logic [5:0]  busy;
        int          exp_mid;
        logic        exp_nack;
        logic [5:0]  exp_sel;
    } txn_t;

    txn_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reqs(input logic fp, input logic [11:0] r);
        if (fp) m_reqs_fp = r;
        else    m_reqs = r;
    endtask

    task automatic shift_sid(input logic [2:0] sid);
        bus_util   = 1'b0;
        bus_serial = sid[2];
        tick();
        check("enter_addr", 32'(o_state), 32'd2);
        bus_serial = sid[1];
        tick();
        bus_serial = sid[0];
        tick();
        check("enter_check", 32'(o_state), 32'd3);
        tick();
    endtask

    task automatic run_txn(input txn_t t);
        logic [11:0] gbit;
        logic [11:0] r;
        gbit   = 12'(1) << t.exp_mid;
        use_fp = t.fp;
        r      = t.reqs;
        set_reqs(t.fp, r);
        slaves_busy = t.busy;
        tick();
        check("grant_state", 32'(o_state), 32'd1);
        check("grant_onehot", 32'(o_grants), 32'(gbit));
        check("grant_mid", 32'(o_mid), 32'(t.exp_mid));
        check("grant_valid", 32'(o_valid), 32'd1);
        shift_sid(t.sid);
        check("check_nack", 32'(o_nack), 32'(t.exp_nack));
        check("check_sel", 32'(o_sel), 32'(t.exp_sel));
        if (!t.exp_nack) begin
            check("connect_state", 32'(o_state), 32'd4);
            tick();
            check("connect_hold_sel", 32'(o_sel), 32'(t.exp_sel));
            check("connect_hold_grant", 32'(o_grants), 32'(gbit));
            set_reqs(t.fp, r & ~gbit);
            bus_util = 1'b1;
            tick();
        end else begin
            set_reqs(t.fp, r & ~gbit);
            bus_util = 1'b1;
        end
        check("release_state", 32'(o_state), 32'd5);
        check("release_grant_still", 32'(o_grants), 32'(gbit));
        tick();
        check("idle_state", 32'(o_state), 32'd0);
        check("idle_grants", 32'(o_grants), 32'd0);
        check("idle_sel", 32'(o_sel), 32'd0);
        check("idle_valid", 32'(o_valid), 32'd0);
        check("idle_mid_hold", 32'(o_mid), 32'(t.exp_mid));
        check("idle_nack_pulse", 32'(o_nack), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit early;
        tbl[0] = '{1'b0, 12'h038, 3'd3, 6'h00, 3, 1'b0, 6'b001000};
        tbl[1] = '{1'b0, 12'h030, 3'd3, 6'h00, 4, 1'b0, 6'b001000};
        tbl[2] = '{1'b0, 12'h020, 3'd3, 6'h00, 5, 1'b0, 6'b001000};
        tbl[3] = '{1'b1, 12'h024, 3'd1, 6'h00, 2, 1'b0, 6'b000010};
        tbl[4] = '{1'b1, 12'h024, 3'd1, 6'h00, 2, 1'b0, 6'b000010};
        tbl[5] = '{1'b0, 12'h008, 3'd4, 6'b010000, 3, 1'b1, 6'b000000};
        tbl[6] = '{1'b0, 12'h002, 3'd7, 6'h00, 1, 1'b1, 6'b000000};

        rst = 1'b1; use_fp = 1'b0;
        m_reqs = '0; m_reqs_fp = '0;
        bus_serial = 1'b1; bus_util = 1'b1; slaves_busy = '0;
        tick(); tick();
        check("rst_state", 32'(st_rr), 32'd0);
        check("rst_grants", 32'(g_rr), 32'd0);
        check("rst_sel", 32'(sel_rr), 32'd0);
        check("rst_mid", 32'(mid_rr), 32'd0);
        check("rst_valid", 32'(val_rr), 32'd0);
        check("rst_pulses", 32'({to_rr, nack_rr}), 32'd0);
        check("rst_fp_grants", 32'(g_fp), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Timeout: master 4 granted while nobody drives the bus.
        use_fp = 1'b0;
        m_reqs = 12'h010;
        tick();
        check("to_grant", 32'(g_rr), 32'h010);
        early = 1'b0;
        for (int k = 1; k < 63; k++) begin
            tick();
            if (to_rr || st_rr != 3'd1) early = 1'b1;
        end
        check("to_not_early", 32'(early), 32'd0);
        tick();
        check("to_pulse", 32'(to_rr), 32'd1);
        check("to_release_state", 32'(st_rr), 32'd5);
        check("to_grant_held", 32'(g_rr), 32'h010);
        m_reqs = '0;
        tick();
        check("to_pulse_end", 32'(to_rr), 32'd0);
        check("to_grant_clear", 32'(g_rr), 32'd0);

        // Pointer is now 5: master 6 must beat master 2, then abort to move pointer to 7.
        run_txn('{1'b0, 12'h044, 3'd7, 6'h00, 6, 1'b1, 6'b000000});

        // Master 5 connects to slave 5, then reset lands mid-cycle.
        m_reqs = 12'h060 & 12'h020;
        tick();
        check("m5_grant", 32'(g_rr), 32'h020);
        shift_sid(3'd5);
        check("m5_connect", 32'(st_rr), 32'd4);
        check("m5_sel", 32'(sel_rr), 32'b100000);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_grants", 32'(g_rr), 32'd0);
        check("async_rst_sel", 32'(sel_rr), 32'd0);
        check("async_rst_state", 32'(st_rr), 32'd0);
        check("async_rst_valid", 32'(val_rr), 32'd0);
        tick();
        rst = 1'b0;
        bus_util = 1'b1;
        m_reqs = 12'h201;
        tick();
        check("post_rst_grant", 32'(g_rr), 32'h001);
        check("post_rst_mid", 32'(mid_rr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
